// File: rtl/nvram_upload_server.sv
// HPS ioctl upload responder: pauses the game, reads its NVRAM/hiscore RAM
// byte by byte through a second RAM port and returns each byte on ioctl_din.
module nvram_upload_server #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DUMP_SIZE   = 1024,
    parameter int unsigned RAM_LATENCY = 2,
    parameter logic [7:0]  DUMP_INDEX  = 8'd4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_index,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              pause_req,
    input  logic              pause_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_q,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAUSE,
        S_READY,
        S_FETCH,
        S_RELEASE
    } state_t;

    // Full-width limit so that e.g. 25'h1000400 cannot alias onto address 0x000.
    localparam logic [24:0] DUMP_LIMIT = 25'(DUMP_SIZE);
    localparam logic [2:0]  LAT_LOAD   = 3'(RAM_LATENCY);

    state_t            state_q, state_d;
    logic [7:0]        din_q, din_d;
    logic              wait_q, wait_d;
    logic              pause_q, pause_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        cnt_q, cnt_d;

    logic session;
    logic in_range;

    assign session  = ioctl_upload && (ioctl_index == DUMP_INDEX);
    assign in_range = (ioctl_addr < DUMP_LIMIT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= S_IDLE;
            din_q   <= 8'h00;
            wait_q  <= 1'b0;
            pause_q <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            wait_q  <= wait_d;
            pause_q <= pause_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every _d gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        wait_d  = wait_q;
        pause_d = pause_q;
        rd_d    = 1'b0;
        addr_d  = addr_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (session) begin
                    state_d = S_PAUSE;
                    pause_d = 1'b1;
                    wait_d  = 1'b1;
                end
            end

            S_PAUSE: begin
                if (!session) begin
                    state_d = S_RELEASE;
                end else if (pause_ack) begin
                    wait_d  = 1'b0;
                    state_d = S_READY;
                end
            end

            S_READY: begin
                if (!session || !pause_ack) begin
                    state_d = S_RELEASE;
                end else if (wait_q) begin
                    // Single stall cycle that follows an out-of-range read.
                    wait_d = 1'b0;
                end else if (ioctl_rd) begin
                    wait_d = 1'b1;
                    if (in_range) begin
                        state_d = S_FETCH;
                        rd_d    = 1'b1;
                        addr_d  = ioctl_addr[ADDR_W-1:0];
                        cnt_d   = LAT_LOAD;
                    end else begin
                        din_d = 8'hFF;
                    end
                end
            end

            S_FETCH: begin
                if (!session || !pause_ack) begin
                    state_d = S_RELEASE;
                end else if (cnt_q == 3'd0) begin
                    din_d   = ram_q;
                    wait_d  = 1'b0;
                    state_d = S_READY;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            S_RELEASE: begin
                pause_d = 1'b0;
                wait_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign pause_req  = pause_q;
    assign ram_rd     = rd_q;
    assign ram_addr   = addr_q;
    assign busy       = (state_q != S_IDLE);

endmodule
